// File: rtl/axi_trace_pkg.sv
// -----------------------------------------------------------------------------
// axi_trace_pkg
// Shared types for the AXI beat recorder: channel codes, capture priority,
// the record layout and the monitored AXI request/response structs.
// -----------------------------------------------------------------------------
`include "axi_trace_typedef.svh"

package axi_trace_pkg;

   localparam int unsigned NUM_CHAN   = 5;
   localparam int unsigned AXI_ID_W   = 4;
   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned REC_TS_W   = 32;
   localparam int unsigned REC_ID_W   = 8;
   localparam int unsigned REC_ADDR_W = 32;

   typedef enum logic [2:0] {
      CH_AW = 3'd0,
      CH_AR = 3'd1,
      CH_W  = 3'd2,
      CH_B  = 3'd3,
      CH_R  = 3'd4
   } chan_e;

   // Highest priority first; only the first qualifying channel is recorded.
   localparam chan_e PRIO_ORDER [NUM_CHAN] = '{CH_AW, CH_AR, CH_W, CH_B, CH_R};

   `AXI_TRACE_TYPEDEF_REC_T(rec_t, REC_TS_W, REC_ID_W, REC_ADDR_W)

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [1:0]            burst;
   } axi_mon_ax_t;

   typedef struct packed {
      axi_mon_ax_t aw;
      logic        aw_valid;
      logic        w_last;
      logic        w_valid;
      axi_mon_ax_t ar;
      logic        ar_valid;
      logic        b_ready;
      logic        r_ready;
   } axi_mon_req_t;

   typedef struct packed {
      logic                aw_ready;
      logic                ar_ready;
      logic                w_ready;
      logic [AXI_ID_W-1:0] b_id;
      logic [1:0]          b_resp;
      logic                b_valid;
      logic [AXI_ID_W-1:0] r_id;
      logic [1:0]          r_resp;
      logic                r_last;
      logic                r_valid;
   } axi_mon_resp_t;

endpackage

// File: rtl/axi_trace_if.sv
// -----------------------------------------------------------------------------
// axi_trace_if
// Bundles the monitored AXI request/response pair and the record drain stream.
//   axi_req / axi_resp : monitored bus (observed only)
//   rd_valid / rd_ready / rd_data : first-word-fall-through record stream
// slave  : the recorder side (observes AXI, drives the stream)
// master : the environment side (drives AXI, consumes the stream)
// -----------------------------------------------------------------------------
interface axi_trace_if;

   axi_trace_pkg::axi_mon_req_t  axi_req;
   axi_trace_pkg::axi_mon_resp_t axi_resp;
   logic                         rd_valid;
   logic                         rd_ready;
   axi_trace_pkg::rec_t          rd_data;

   modport slave (
      input  axi_req, axi_resp, rd_ready,
      output rd_valid, rd_data
   );

   modport master (
      output axi_req, axi_resp, rd_ready,
      input  rd_valid, rd_data
   );

endinterface

// File: rtl/axi_trace_fifo.sv
// -----------------------------------------------------------------------------
// axi_trace_fifo
// Circular record buffer with first-word-fall-through read.
//   clk_i, rst_i          : clock, async active-high reset
//   clear_i               : synchronous flush (wins over push and pop)
//   wrap_i                : when full, overwrite the oldest entry instead of dropping
//   push_i, push_data_i   : write one record
//   drop_o                : push discarded this cycle (full, no wrap, no pop)
//   rd_valid_o/rd_ready_i/rd_data_o : head record stream
//   count_o               : occupancy 0..Depth
//   overflow_o            : sticky, set when an entry was overwritten
// -----------------------------------------------------------------------------
module axi_trace_fifo
   import axi_trace_pkg::*;
#(
   parameter  int unsigned Depth    = 64,
   localparam int unsigned PtrWidth = $clog2(Depth),
   localparam int unsigned CntWidth = PtrWidth + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                wrap_i,
   input  logic                push_i,
   input  rec_t                push_data_i,
   output logic                drop_o,
   output logic                rd_valid_o,
   input  logic                rd_ready_i,
   output rec_t                rd_data_o,
   output logic [CntWidth-1:0] count_o,
   output logic                overflow_o
);

   rec_t                mem_q [Depth];
   logic [PtrWidth-1:0] wptr_q, rptr_q;
   logic [CntWidth-1:0] cnt_q;
   logic                ovf_q;
   logic                full, pop, wr_en, overwrite;

   assign full       = (cnt_q == CntWidth'(Depth));
   assign rd_valid_o = (cnt_q != '0);
   assign pop        = rd_valid_o & rd_ready_i;
   assign rd_data_o  = mem_q[rptr_q];
   assign count_o    = cnt_q;
   assign overflow_o = ovf_q;

   // A same-cycle pop frees a slot, so a push into a full buffer only
   // overwrites or drops when nothing is being read out.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      wr_en     = 1'b0;
      overwrite = 1'b0;
      drop_o    = 1'b0;
      if (push_i) begin
         if (!full || pop) begin
            wr_en = 1'b1;
         end else if (wrap_i) begin
            wr_en     = 1'b1;
            overwrite = 1'b1;
         end else begin
            drop_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else if (clear_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            wptr_q <= wptr_q + PtrWidth'(1);
         end
         if (pop || overwrite) begin
            rptr_q <= rptr_q + PtrWidth'(1);
         end
         if (wr_en && !overwrite && !pop) begin
            cnt_q <= cnt_q + CntWidth'(1);
         end else if (pop && !wr_en) begin
            cnt_q <= cnt_q - CntWidth'(1);
         end
         if (overwrite) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // NOTE: storage has no reset; the pointers and count define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (wr_en && !clear_i) begin
         mem_q[wptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/axi_trace_typedef.svh
// -----------------------------------------------------------------------------
// axi_trace_typedef.svh
// Typedef macro for the trace record. The macro lets a package (or a user
// block with different field widths) stamp out a record struct. It expects
// chan_e to be visible where it is expanded.
// -----------------------------------------------------------------------------
`ifndef AXI_TRACE_TYPEDEF_SVH
`define AXI_TRACE_TYPEDEF_SVH

`define AXI_TRACE_TYPEDEF_REC_T(rec_name, ts_w, id_w, addr_w) \
   typedef struct packed {                                     \
      logic [(ts_w)-1:0]   ts;                                 \
      chan_e               chan;                               \
      logic [(id_w)-1:0]   id;                                 \
      logic [(addr_w)-1:0] addr;                               \
      logic [7:0]          len;                                \
      logic [3:0]          meta;                               \
   } rec_name;

`endif

// File: rtl/axi_trace_buffer.sv
// -----------------------------------------------------------------------------
// axi_trace_buffer
// Passive AXI beat recorder. Qualifies handshakes on AW/AR/W/B/R, keeps the
// highest-priority one per cycle as a timestamped record in a circular buffer
// and counts every qualifying beat that could not be stored.
//   clk_i, rst_i   : clock, async active-high reset
//   bus            : monitored AXI pair plus record drain stream (slave side)
//   en_i           : capture enable; timestamp advances only while high
//   chan_mask_i    : per-channel enable {R,B,W,AR,AW}
//   wrap_i         : 1 overwrite oldest when full, 0 stop when full
//   clear_i        : synchronous flush of buffer, timestamp and counters
//   count_o        : occupancy
//   overflow_o     : sticky overwrite flag
//   drop_cnt_o     : saturating count of unrecorded beats
// -----------------------------------------------------------------------------
module axi_trace_buffer
   import axi_trace_pkg::*;
#(
   parameter  type         axi_req_t    = axi_trace_pkg::axi_mon_req_t,
   parameter  type         axi_resp_t   = axi_trace_pkg::axi_mon_resp_t,
   parameter  int unsigned IdWidth      = AXI_ID_W,
   parameter  int unsigned AddrWidth    = AXI_ADDR_W,
   parameter  int unsigned Depth        = 64,
   parameter  int unsigned TsWidth      = 32,
   parameter  int unsigned DropCntWidth = 16,
   localparam int unsigned CntWidth     = $clog2(Depth) + 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   axi_trace_if.slave              bus,
   input  logic                    en_i,
   input  logic [NUM_CHAN-1:0]     chan_mask_i,
   input  logic                    wrap_i,
   input  logic                    clear_i,
   output logic [CntWidth-1:0]     count_o,
   output logic                    overflow_o,
   output logic [DropCntWidth-1:0] drop_cnt_o
);

   localparam int unsigned QW = $clog2(NUM_CHAN + 1);

   axi_req_t                req;
   axi_resp_t               resp;
   logic [NUM_CHAN-1:0]     hs, qual;
   logic [QW-1:0]           n_qual, drop_inc;
   logic                    sel_valid, fifo_drop;
   chan_e                   sel_chan;
   rec_t                    rec;
   logic [TsWidth-1:0]      ts_q;
   logic [DropCntWidth-1:0] drop_q;
   logic [DropCntWidth:0]   drop_sum;

   assign req  = bus.axi_req;
   assign resp = bus.axi_resp;

   // Bit order matches chan_e codes and chan_mask_i.
   assign hs = {resp.r_valid  & req.r_ready,
                resp.b_valid  & req.b_ready,
                req.w_valid   & resp.w_ready,
                req.ar_valid  & resp.ar_ready,
                req.aw_valid  & resp.aw_ready};
   assign qual   = hs & chan_mask_i & {NUM_CHAN{en_i}};
   assign n_qual = QW'($countones(qual));

   // Walk from lowest to highest priority so the last match wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_chan  = CH_AW;
      for (int i = NUM_CHAN - 1; i >= 0; i--) begin
         if (qual[PRIO_ORDER[i]]) begin
            sel_valid = 1'b1;
            sel_chan  = PRIO_ORDER[i];
         end
      end
   end

   // AXI IDs and addresses are first taken at the configured bus width,
   // then zero-extended or truncated into the fixed record fields.
   always_comb begin
      rec      = '0;
      rec.ts   = REC_TS_W'(ts_q);
      rec.chan = sel_chan;
      case (sel_chan)
         CH_AW: begin
            rec.id   = REC_ID_W'(IdWidth'(req.aw.id));
            rec.addr = REC_ADDR_W'(AddrWidth'(req.aw.addr));
            rec.len  = req.aw.len;
            rec.meta = {req.aw.burst, 2'b00};
         end
         CH_AR: begin
            rec.id   = REC_ID_W'(IdWidth'(req.ar.id));
            rec.addr = REC_ADDR_W'(AddrWidth'(req.ar.addr));
            rec.len  = req.ar.len;
            rec.meta = {req.ar.burst, 2'b00};
         end
         CH_W: begin
            rec.meta = {2'b00, req.w_last, 1'b0};
         end
         CH_B: begin
            rec.id   = REC_ID_W'(IdWidth'(resp.b_id));
            rec.meta = {resp.b_resp, 2'b00};
         end
         CH_R: begin
            rec.id   = REC_ID_W'(IdWidth'(resp.r_id));
            rec.meta = {resp.r_resp, resp.r_last, 1'b0};
         end
         default: ;
      endcase
   end

   axi_trace_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear_i),
      .wrap_i      (wrap_i),
      .push_i      (sel_valid),
      .push_data_i (rec),
      .drop_o      (fifo_drop),
      .rd_valid_o  (bus.rd_valid),
      .rd_ready_i  (bus.rd_ready),
      .rd_data_o   (bus.rd_data),
      .count_o     (count_o),
      .overflow_o  (overflow_o)
   );

   // Losers of the priority select, plus the winner when the buffer refuses it.
   assign drop_inc = n_qual - QW'(sel_valid) + QW'(fifo_drop);
   assign drop_sum = {1'b0, drop_q} + (DropCntWidth + 1)'(drop_inc);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ts_q   <= '0;
         drop_q <= '0;
      end else if (clear_i) begin
         ts_q   <= '0;
         drop_q <= '0;
      end else begin
         if (en_i) begin
            ts_q <= ts_q + TsWidth'(1);
         end
         drop_q <= drop_sum[DropCntWidth] ? '1 : drop_sum[DropCntWidth-1:0];
      end
   end

   assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_axi_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_axi_trace_buffer
// Scoreboard bench for axi_trace_buffer with a 4-entry buffer. Expected
// records are queued as beats are driven and compared as the stream drains.
// -----------------------------------------------------------------------------
module tb_axi_trace_buffer;
   import axi_trace_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned DROP_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [4:0]        mask = '0;
   logic              wrap = 1'b0;
   logic              clear = 1'b0;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;

   axi_trace_if bus ();

   axi_trace_buffer #(
      .axi_req_t    (axi_mon_req_t),
      .axi_resp_t   (axi_mon_resp_t),
      .IdWidth      (AXI_ID_W),
      .AddrWidth    (AXI_ADDR_W),
      .Depth        (DEPTH),
      .TsWidth      (32),
      .DropCntWidth (DROP_W)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .en_i        (en),
      .chan_mask_i (mask),
      .wrap_i      (wrap),
      .clear_i     (clear),
      .count_o     (count),
      .overflow_o  (overflow),
      .drop_cnt_o  (drop_cnt)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   rec_t        sb[$];
   rec_t        exp_rec;
   logic [31:0] ts_m = '0;
   int unsigned drop_m = 0;

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1);
   end

   // One clock: reference timestamp follows clear/en; returns at the negedge.
   task automatic cycle();
      @(posedge clk);
      if (clear)   ts_m = '0;
      else if (en) ts_m = ts_m + 32'd1;
      @(negedge clk);
   endtask

   function automatic rec_t mk_rec(chan_e c, logic [31:0] ts, logic [3:0] id,
                                   logic [31:0] addr, logic [7:0] len, logic [3:0] meta);
      rec_t r;
      r.ts   = ts;
      r.chan = c;
      r.id   = REC_ID_W'(id);
      r.addr = addr;
      r.len  = len;
      r.meta = meta;
      return r;
   endfunction

   task automatic idle_axi();
      bus.axi_req  = '0;
      bus.axi_resp = '0;
   endtask

   task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      bus.axi_req.aw.id = id; bus.axi_req.aw.addr = addr; bus.axi_req.aw.len = len; bus.axi_req.aw.burst = burst;
      bus.axi_req.aw_valid = 1'b1; bus.axi_resp.aw_ready = 1'b1;
   endtask

   task automatic set_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      bus.axi_req.ar.id = id; bus.axi_req.ar.addr = addr; bus.axi_req.ar.len = len; bus.axi_req.ar.burst = burst;
      bus.axi_req.ar_valid = 1'b1; bus.axi_resp.ar_ready = 1'b1;
   endtask

   task automatic set_w(input logic last);
      bus.axi_req.w_last = last; bus.axi_req.w_valid = 1'b1; bus.axi_resp.w_ready = 1'b1;
   endtask

   task automatic set_b(input logic [3:0] id, input logic [1:0] rsp);
      bus.axi_resp.b_id = id; bus.axi_resp.b_resp = rsp; bus.axi_resp.b_valid = 1'b1; bus.axi_req.b_ready = 1'b1;
   endtask

   task automatic set_r(input logic [3:0] id, input logic [1:0] rsp, input logic last);
      bus.axi_resp.r_id = id; bus.axi_resp.r_resp = rsp; bus.axi_resp.r_last = last;
      bus.axi_resp.r_valid = 1'b1; bus.axi_req.r_ready = 1'b1;
   endtask

   task automatic do_clear();
      idle_axi();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      sb.delete();
      drop_m = 0;
   endtask

   task automatic test_reset();
      idle_axi();
      bus.rd_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ts_m = '0;
      checks++; if (count !== '0)       begin failures++; $display("FAIL reset_count: got %0d exp 0", count); end
      checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b exp 0", bus.rd_valid); end
      checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
      checks++; if (drop_cnt !== '0)    begin failures++; $display("FAIL reset_drop: got %0d exp 0", drop_cnt); end
   endtask

   task automatic test_single_aw();
      mask = 5'b00001; en = 1'b1; wrap = 1'b0;
      repeat (5) cycle();
      set_aw(4'd3, 32'h1000, 8'd7, 2'b01);
      sb.push_back(mk_rec(CH_AW, ts_m, 4'd3, 32'h1000, 8'd7, 4'b0100));
      checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL single_pre_valid: got %b exp 0", bus.rd_valid); end
      cycle();
      idle_axi();
      checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b exp 1", bus.rd_valid); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d exp 1", count); end
      checks++; if (bus.rd_data.ts !== 32'd5) begin failures++; $display("FAIL single_ts: got %0d exp 5", bus.rd_data.ts); end
      while (sb.size() != 0) begin
         exp_rec = sb.pop_front();
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec) begin
            failures++; $display("FAIL single_drain: valid %b got %h exp %h", bus.rd_valid, bus.rd_data, exp_rec);
         end
         bus.rd_ready = 1'b1; cycle(); bus.rd_ready = 1'b0;
      end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_empty: got %0d exp 0", count); end
   endtask

   task automatic test_same_cycle();
      mask = 5'b11111;
      set_aw(4'd5, 32'h2000, 8'd0, 2'b10);
      set_r(4'd9, 2'b10, 1'b1);
      sb.push_back(mk_rec(CH_AW, ts_m, 4'd5, 32'h2000, 8'd0, 4'b1000));
      cycle();
      idle_axi();
      checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL same_drop1: got %0d exp 1", drop_cnt); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL same_count1: got %0d exp 1", count); end
      mask = 5'b11110;
      set_aw(4'd1, 32'h3000, 8'd1, 2'b01);
      set_w(1'b1);
      set_b(4'd6, 2'b01);
      sb.push_back(mk_rec(CH_W, ts_m, 4'd0, 32'd0, 8'd0, 4'b0010));
      cycle();
      idle_axi();
      mask = 5'b01111;
      set_r(4'd2, 2'b00, 1'b0);
      cycle();
      idle_axi();
      en = 1'b0; mask = 5'b11111;
      set_ar(4'd4, 32'h40, 8'd2, 2'b01);
      cycle();
      cycle();
      idle_axi();
      en = 1'b1;
      checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL same_drop2: got %0d exp 2", drop_cnt); end
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL same_count2: got %0d exp 2", count); end
      set_b(4'd6, 2'b01);
      sb.push_back(mk_rec(CH_B, ts_m, 4'd6, 32'd0, 8'd0, 4'b0100));
      cycle();
      idle_axi();
      set_r(4'd9, 2'b10, 1'b1);
      sb.push_back(mk_rec(CH_R, ts_m, 4'd9, 32'd0, 8'd0, 4'b1010));
      cycle();
      idle_axi();
      while (sb.size() != 0) begin
         exp_rec = sb.pop_front();
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec) begin
            failures++; $display("FAIL same_drain: valid %b got %h exp %h", bus.rd_valid, bus.rd_data, exp_rec);
         end
         bus.rd_ready = 1'b1; cycle(); bus.rd_ready = 1'b0;
      end
   endtask

   task automatic test_stop_when_full();
      do_clear();
      checks++; if (count !== 3'd0 || drop_cnt !== '0) begin failures++; $display("FAIL clear_state: count %0d drop %0d exp 0 0", count, drop_cnt); end
      wrap = 1'b0; mask = 5'b00010;
      for (int k = 1; k <= 6; k++) begin
         set_ar(4'(k), 32'(k * 32'h100), 8'(k), 2'b01);
         if (k <= 4) sb.push_back(mk_rec(CH_AR, ts_m, 4'(k), 32'(k * 32'h100), 8'(k), 4'b0100));
         cycle();
      end
      idle_axi();
      checks++; if (count !== 3'd4)      begin failures++; $display("FAIL stop_count: got %0d exp 4", count); end
      checks++; if (drop_cnt !== 16'd2)  begin failures++; $display("FAIL stop_drop: got %0d exp 2", drop_cnt); end
      checks++; if (overflow !== 1'b0)   begin failures++; $display("FAIL stop_overflow: got %b exp 0", overflow); end
      while (sb.size() != 0) begin
         exp_rec = sb.pop_front();
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec) begin
            failures++; $display("FAIL stop_drain: valid %b got %h exp %h", bus.rd_valid, bus.rd_data, exp_rec);
         end
         bus.rd_ready = 1'b1; cycle(); bus.rd_ready = 1'b0;
      end
   endtask

   task automatic test_wrap();
      do_clear();
      wrap = 1'b1; mask = 5'b00010;
      for (int k = 1; k <= 6; k++) begin
         set_ar(4'(k), 32'(k * 32'h100), 8'(k), 2'b01);
         sb.push_back(mk_rec(CH_AR, ts_m, 4'(k), 32'(k * 32'h100), 8'(k), 4'b0100));
         if (sb.size() > DEPTH) void'(sb.pop_front());
         cycle();
      end
      idle_axi();
      wrap = 1'b0;
      checks++; if (count !== 3'd4)     begin failures++; $display("FAIL wrap_count: got %0d exp 4", count); end
      checks++; if (overflow !== 1'b1)  begin failures++; $display("FAIL wrap_overflow: got %b exp 1", overflow); end
      checks++; if (drop_cnt !== '0)    begin failures++; $display("FAIL wrap_drop: got %0d exp 0", drop_cnt); end
      while (sb.size() != 0) begin
         exp_rec = sb.pop_front();
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec) begin
            failures++; $display("FAIL wrap_drain: valid %b got %h exp %h", bus.rd_valid, bus.rd_data, exp_rec);
         end
         bus.rd_ready = 1'b1; cycle(); bus.rd_ready = 1'b0;
      end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL wrap_sticky: got %b exp 1", overflow); end
   endtask

   task automatic test_full_pop_write();
      do_clear();
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow: got %b exp 0", overflow); end
      wrap = 1'b0; mask = 5'b00010;
      for (int k = 1; k <= 4; k++) begin
         set_ar(4'(k), 32'(32'hA000 + k), 8'(k), 2'b00);
         sb.push_back(mk_rec(CH_AR, ts_m, 4'(k), 32'(32'hA000 + k), 8'(k), 4'b0000));
         cycle();
      end
      set_ar(4'd5, 32'hA005, 8'd5, 2'b00);
      exp_rec = sb.pop_front();
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec) begin
         failures++; $display("FAIL fpw_head: valid %b got %h exp %h", bus.rd_valid, bus.rd_data, exp_rec);
      end
      sb.push_back(mk_rec(CH_AR, ts_m, 4'd5, 32'hA005, 8'd5, 4'b0000));
      bus.rd_ready = 1'b1; cycle(); bus.rd_ready = 1'b0;
      idle_axi();
      checks++; if (count !== 3'd4)    begin failures++; $display("FAIL fpw_count: got %0d exp 4", count); end
      checks++; if (drop_cnt !== '0)   begin failures++; $display("FAIL fpw_drop: got %0d exp 0", drop_cnt); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpw_overflow: got %b exp 0", overflow); end
      while (sb.size() != 0) begin
         exp_rec = sb.pop_front();
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec) begin
            failures++; $display("FAIL fpw_drain: valid %b got %h exp %h", bus.rd_valid, bus.rd_data, exp_rec);
         end
         bus.rd_ready = 1'b1; cycle(); bus.rd_ready = 1'b0;
      end
   endtask

   task automatic test_drop_saturate();
      int unsigned occ_m;
      int unsigned inc;
      do_clear();
      occ_m = 0;
      wrap = 1'b0; mask = 5'b11111;
      set_aw(4'd7, 32'hF0, 8'd0, 2'b01);
      set_ar(4'd8, 32'hF4, 8'd0, 2'b01);
      set_w(1'b0);
      set_b(4'd1, 2'b00);
      set_r(4'd2, 2'b00, 1'b0);
      for (int i = 0; i < 13200; i++) begin
         if (occ_m < DEPTH) begin occ_m++; inc = 4; end
         else inc = 5;
         drop_m = (drop_m + inc > 65535) ? 65535 : drop_m + inc;
         cycle();
         if (i == 99) begin
            checks++;
            if (drop_cnt !== DROP_W'(drop_m)) begin failures++; $display("FAIL sat_mid: got %0d exp %0d", drop_cnt, drop_m); end
         end
      end
      idle_axi();
      checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_drop: got %h exp ffff", drop_cnt); end
      checks++; if (count !== 3'd4)        begin failures++; $display("FAIL sat_count: got %0d exp 4", count); end
   endtask

   task automatic test_clear_and_reset();
      mask = 5'b11111; en = 1'b1; wrap = 1'b0;
      idle_axi();
      set_b(4'd3, 2'b11);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      idle_axi();
      sb.delete();
      checks++; if (count !== 3'd0)        begin failures++; $display("FAIL clr_count: got %0d exp 0", count); end
      checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL clr_valid: got %b exp 0", bus.rd_valid); end
      checks++; if (drop_cnt !== '0)       begin failures++; $display("FAIL clr_drop: got %0d exp 0", drop_cnt); end
      set_b(4'd3, 2'b11);
      sb.push_back(mk_rec(CH_B, ts_m, 4'd3, 32'd0, 8'd0, 4'b1100));
      cycle();
      idle_axi();
      exp_rec = sb.pop_front();
      checks++;
      if (bus.rd_data !== exp_rec || exp_rec.ts !== 32'd0) begin
         failures++; $display("FAIL clr_ts_restart: got %h exp %h", bus.rd_data, exp_rec);
      end
      wrap = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_ar(4'(k), 32'(k), 8'd1, 2'b01);
         cycle();
      end
      set_aw(4'd9, 32'h99, 8'd3, 2'b01);
      cycle();
      checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin failures++; $display("FAIL pre_rst: ovf %b drop %0d exp 1 1", overflow, drop_cnt); end
      #2 rst = 1'b1;
      #1;
      checks++; if (count !== 3'd0)        begin failures++; $display("FAIL rst_count: got %0d exp 0", count); end
      checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", bus.rd_valid); end
      checks++; if (overflow !== 1'b0 || drop_cnt !== '0) begin failures++; $display("FAIL rst_flags: ovf %b drop %0d exp 0 0", overflow, drop_cnt); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ts_m = '0;
      sb.delete();
      idle_axi();
      wrap = 1'b0;
      set_ar(4'd12, 32'hBEEF, 8'd4, 2'b10);
      sb.push_back(mk_rec(CH_AR, ts_m, 4'd12, 32'hBEEF, 8'd4, 4'b1000));
      cycle();
      idle_axi();
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL rst_after_count: got %0d exp 1", count); end
      while (sb.size() != 0) begin
         exp_rec = sb.pop_front();
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rec) begin
            failures++; $display("FAIL rst_after_drain: valid %b got %h exp %h", bus.rd_valid, bus.rd_data, exp_rec);
         end
         bus.rd_ready = 1'b1; cycle(); bus.rd_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single_aw();
      test_same_cycle();
      test_stop_when_full();
      test_wrap();
      test_full_pop_write();
      test_drop_saturate();
      test_clear_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi_trace_buffer.md
Name: axi_trace_buffer

Overview:
Synthesizable, parametrised AXI beat recorder. Passively monitors one AXI req/resp pair and captures handshaked beats from a run-time selectable set of channels (AW, AR, W, B, R), each tagged with a timestamp, into an on-chip circular buffer. A valid/ready stream drains the buffer. Replaces file-based, simulation-only dumping wherever traces must survive into FPGA/silicon builds.

Parameters:
axi_req_t, logic, AXI request struct type (aw/w/ar/b_ready/r_ready fields)
axi_resp_t, logic, AXI response struct type
IdWidth, 4, AXI ID width; IDs are truncated/zero-extended into the record
AddrWidth, 32, AXI address width
Depth, 64, buffer entries; power of two, minimum 2
TsWidth, 32, timestamp counter width
DropCntWidth, 16, saturating dropped-beat counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
axi_req_i  in  axi_req_t  monitored request
axi_resp_i  in  axi_resp_t  monitored response
en_i  in  1  capture enable; timestamp runs only while high
chan_mask_i  in  5  per-channel enable {R,B,W,AR,AW}, bit0 = AW
wrap_i  in  1  1: overwrite oldest when full; 0: stop-when-full
clear_i  in  1  synchronous flush of buffer, counters and flags
rd_valid_o  out  1  head record available
rd_ready_i  in  1  consumer accepts head record
rd_data_o  out  axi_trace_pkg::rec_t  head record
count_o  out  $clog2(Depth)+1  occupancy
overflow_o  out  1  sticky: at least one record overwritten (wrap mode)
drop_cnt_o  out  DropCntWidth  saturating count of beats not recorded

Behaviour:
- Reset (rst_i high, async): buffer empty, pointers 0, count_o=0, rd_valid_o=0, overflow_o=0, drop_cnt_o=0, timestamp=0. rd_data_o content is don't-care while rd_valid_o=0.
- Handshake event on channel c: the channel's valid & ready, with chan_mask_i[c] & en_i.
- Record fields: ts (timestamp at the handshake cycle), chan (3b code AW=0, AR=1, W=2, B=3, R=4), id (AW/AR/B/R id; 0 for W), addr (AW/AR addr, else 0), len (AW/AR len, else 0), meta (4b: B/R {resp[1:0], last, 0}, W {0,0,last,0}, AW/AR {burst[1:0], 0,0}).
- At most one record is written per cycle. Priority: AW > AR > W > B > R. Every other qualifying event in the same cycle increments drop_cnt_o.
- Latency: event in cycle N; record visible at the head (rd_valid_o=1) in cycle N+1 if the buffer was empty.
- Read: first-word-fall-through. rd_data_o = entry at the read pointer; pop on rd_valid_o & rd_ready_i.
- Full, wrap_i=1: the write overwrites the oldest entry, the read pointer advances, count_o stays Depth, and overflow_o is set.
- Full, wrap_i=0: the record is discarded and drop_cnt_o increments.
- Full with a simultaneous pop: the pop frees an entry. The write lands normally, with no overwrite and no drop, and count_o is unchanged.
- Empty with a simultaneous write: no pop occurs. count_o becomes 1.
- Pointers wrap modulo Depth. The timestamp counter wraps modulo 2^TsWidth.
- drop_cnt_o saturates at all-ones.
- clear_i takes priority over every same-cycle write and pop. It empties the buffer and zeroes the timestamp, overflow_o and drop_cnt_o.
- en_i low: no capture, timestamp frozen, reads still served.
- Changing chan_mask_i or wrap_i takes effect in the same cycle.
- Reset mid-operation discards all content; no partial record survives.

Decomposition:
- Package axi_trace_pkg holds:
  - chan_e enum (3b codes)
  - rec_t packed struct, parametrised via a typedef macro in axi_trace_typedef.svh (ts, chan, id, addr, len, meta)
  - priority order constant
- Sub-module axi_trace_fifo: circular flop/RAM buffer with push, pop, wrap-overwrite, clear, count.
- The top level contains the event qualification, priority select, record packing, timestamp counter and drop counter.

Test Plan:
- Single AW (id=3, addr=0x1000, len=7) at ts=5, mask=5'b00001 -> one record {ts=5, chan=0, id=3, addr=0x1000, len=7}; rd_valid_o high 1 cycle after the handshake.
- AW and R handshake in the same cycle, mask=5'b11111 -> only the AW record is stored; drop_cnt_o=1.
- Depth=4, wrap_i=0, 6 AR beats, no reads -> count_o=4, records 1-4 kept, drop_cnt_o=2, overflow_o=0.
- Depth=4, wrap_i=1, 6 AR beats -> count_o=4, records 3-6 read out in order, overflow_o=1, drop_cnt_o=0.
- Buffer full, write and pop in the same cycle (wrap_i=0) -> count_o stays 4, no drop, the new record is last in order.
- clear_i asserted with a simultaneous B handshake, then rst_i pulsed mid-burst -> count_o=0, drop_cnt_o=0, timestamp restarts at 0, rd_valid_o=0.
